// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipe delay line: default sizes, count width and parity helpers.
// Parity helpers are only referenced when DFF_PIPE_PARITY_EN is defined.
package dff_pkg;

    localparam int DFF_DEF_WIDTH = 8;
    localparam int DFF_DEF_DEPTH = 4;

    // Parity operand is zero-extended to this width; extension does not change parity.
    localparam int DFF_PAR_MAX_W = 1024;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_step_e;

    function automatic int clog2_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic even_parity(input logic [DFF_PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH-bit data plus valid bit (plus parity when DFF_PIPE_PARITY_EN is defined),
// with asynchronous active-low reset, synchronous flush and advance enable.
module dff_stage import dff_pkg::*; #(
    parameter int               WIDTH   = DFF_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_valid,
`ifdef DFF_PIPE_PARITY_EN
    input  logic             i_par,
    output logic             o_par,
`endif
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= RST_VAL;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_data  <= RST_VAL;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_data  <= i_d;
            r_valid <= i_valid;
        end
    end

`ifdef DFF_PIPE_PARITY_EN
    logic r_par;

    // Reset/flush parity matches RST_VAL so an empty stage is self-consistent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= ^RST_VAL;
        end else if (i_flush) begin
            r_par <= ^RST_VAL;
        end else if (i_en) begin
            r_par <= i_par;
        end
    end

    assign o_par = r_par;
`endif

    assign o_q     = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH register delay line with per-stage valid, stall, flush and registered occupancy count.
// Define DFF_PIPE_PARITY_EN to add per-stage even parity, a par_err output and a par_inject debug input.
module dff_pipe import dff_pkg::*; #(
    parameter int               WIDTH   = DFF_DEF_WIDTH,
    parameter int               DEPTH   = DFF_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              d,
    input  logic                          d_valid,
    output logic [WIDTH-1:0]              q,
    output logic                          q_valid,
    output logic [clog2_depth(DEPTH)-1:0] count
`ifdef DFF_PIPE_PARITY_EN
    ,
    input  logic                          par_inject,
    output logic                          par_err
`endif
);

    localparam int CW = clog2_depth(DEPTH);

    // d_valid only qualifies d; there is no backpressure, en=0 freezes the whole chain.
    logic [WIDTH-1:0] w_data  [DEPTH];
    logic             w_valid [DEPTH];
`ifdef DFF_PIPE_PARITY_EN
    logic             w_par   [DEPTH];
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_d_in;
        logic             w_v_in;
`ifdef DFF_PIPE_PARITY_EN
        logic             w_p_in;
`endif

        if (i == 0) begin : g_head
            assign w_d_in = d;
            assign w_v_in = d_valid;
`ifdef DFF_PIPE_PARITY_EN
            assign w_p_in = even_parity(DFF_PAR_MAX_W'(d)) ^ par_inject;
`endif
        end else begin : g_body
            assign w_d_in = w_data[i-1];
            assign w_v_in = w_valid[i-1];
`ifdef DFF_PIPE_PARITY_EN
            assign w_p_in = w_par[i-1];
`endif
        end

        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (en),
            .i_flush (flush),
            .i_d     (w_d_in),
            .i_valid (w_v_in),
`ifdef DFF_PIPE_PARITY_EN
            .i_par   (w_p_in),
            .o_par   (w_par[i]),
`endif
            .o_q     (w_data[i]),
            .o_valid (w_valid[i])
        );
    end

    // Count tracks entries in minus entries out, so it never needs a popcount.
    cnt_step_e     w_step;
    logic [CW-1:0] r_count;

    always_comb begin
        w_step = CNT_HOLD;
        if (d_valid && !w_valid[DEPTH-1]) begin
            w_step = CNT_INC;
        end else if (!d_valid && w_valid[DEPTH-1]) begin
            w_step = CNT_DEC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (en) begin
            case (w_step)
                CNT_INC: r_count <= r_count + CW'(1);
                CNT_DEC: r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef DFF_PIPE_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_err <= 1'b0;
        end else if (flush) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_valid[DEPTH-1] &&
                         (even_parity(DFF_PAR_MAX_W'(w_data[DEPTH-1])) != w_par[DEPTH-1]);
        end
    end

    assign par_err = r_par_err;
`endif

    assign q       = w_data[DEPTH-1];
    assign q_valid = w_valid[DEPTH-1];
    assign count   = r_count;

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk) disable iff (!rst)
        r_count <= CW'(DEPTH));
    a_count_min: assert property (@(posedge clk) disable iff (!rst)
        !(en && !flush && (w_step == CNT_DEC) && (r_count == '0)));
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4): vector table, corner sequences, random run.
// Parity checks are compiled in when DFF_PIPE_PARITY_EN is defined.
module tb_dff_pipe;

    localparam int               WIDTH   = 8;
    localparam int               DEPTH   = 4;
    localparam logic [WIDTH-1:0] RST_VAL = '0;
    localparam int               CW      = $clog2(DEPTH + 1);
    localparam int               W       = WIDTH + 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    count;
`ifdef DFF_PIPE_PARITY_EN
    logic             par_inject;
    logic             par_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int max_cnt;

    // Entries still travelling toward q, oldest first; exp_out is {q_valid, q} the DUT should show.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_out;

    typedef struct {
        logic             en;
        logic             flush;
        logic [WIDTH-1:0] d;
        logic             dv;
        logic [WIDTH-1:0] eq;
        logic             eqv;
        int               ecnt;
    } vec_t;

    vec_t vecs[12];

    dff_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .d          (d),
        .d_valid    (d_valid),
        .q          (q),
        .q_valid    (q_valid),
        .count      (count)
`ifdef DFF_PIPE_PARITY_EN
        ,
        .par_inject (par_inject),
        .par_err    (par_err)
`endif
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_reset();
        exp_q.delete();
        for (int i = 0; i < DEPTH - 1; i++) exp_q.push_back({1'b0, RST_VAL});
        exp_out = {1'b0, RST_VAL};
    endtask

    function automatic int sb_count();
        int c = int'(exp_out[W-1]);
        foreach (exp_q[i]) c += int'(exp_q[i][W-1]);
        return c;
    endfunction

    task automatic sb_compare(input string tag);
        check({tag, "_q"},       32'(q),       32'(exp_out[WIDTH-1:0]));
        check({tag, "_q_valid"}, 32'(q_valid), 32'(exp_out[W-1]));
        check({tag, "_count"},   32'(count),   32'(sb_count()));
    endtask

    // Driver: apply one cycle of inputs, update the model at the edge, compare 1 time unit later.
    task automatic drive(input logic i_en, input logic i_fl, input logic [WIDTH-1:0] i_d,
                         input logic i_dv);
        en      = i_en;
        flush   = i_fl;
        d       = i_d;
        d_valid = i_dv;
        @(posedge clk);
        if (i_fl) begin
            sb_reset();
        end else if (i_en) begin
            exp_q.push_back({i_dv, i_d});
            exp_out = exp_q.pop_front();
        end
        #1;
        sb_compare("sb");
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 8'h00, 1'b0, 1};
        vecs[1]  = '{1'b1, 1'b0, 8'h22, 1'b1, 8'h00, 1'b0, 2};
        vecs[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 8'h00, 1'b0, 3};
        vecs[3]  = '{1'b1, 1'b0, 8'h44, 1'b1, 8'h11, 1'b1, 4};
        vecs[4]  = '{1'b1, 1'b0, 8'h55, 1'b1, 8'h22, 1'b1, 4};
        vecs[5]  = '{1'b1, 1'b0, 8'h66, 1'b0, 8'h33, 1'b1, 3};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 2};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h55, 1'b1, 1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h66, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b0, 8'h99, 1'b1, 8'h66, 1'b0, 0};
        vecs[10] = '{1'b0, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0, 0};
        vecs[11] = '{1'b1, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0, 0};

        // Reset held while inputs try to load data
        rst     = 1'b0;
        en      = 1'b1;
        flush   = 1'b0;
        d       = 8'hA5;
        d_valid = 1'b1;
`ifdef DFF_PIPE_PARITY_EN
        par_inject = 1'b0;
`endif
        sb_reset();
        #2;
        check("rst_async_q", 32'(q), 32'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_q",       32'(q),       32'h00);
            check("rst_q_valid", 32'(q_valid), 32'h0);
            check("rst_count",   32'(count),   32'h0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Table-driven latency / drain / stall / flush vectors
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].flush, vecs[i].d, vecs[i].dv);
            check($sformatf("vec%0d_q", i),       32'(q),       32'(vecs[i].eq));
            check($sformatf("vec%0d_q_valid", i), 32'(q_valid), 32'(vecs[i].eqv));
            check($sformatf("vec%0d_count", i),   32'(count),   32'(vecs[i].ecnt));
        end

        // Asynchronous reset mid-stream, away from any clock edge
        drive(1'b1, 1'b0, 8'hAA, 1'b1);
        drive(1'b1, 1'b0, 8'hBB, 1'b1);
        drive(1'b1, 1'b0, 8'hCC, 1'b1);
        drive(1'b1, 1'b0, 8'hDD, 1'b1);
        check("pre_arst_q", 32'(q), 32'hAA);
        #3;
        rst = 1'b0;
        #1;
        check("arst_q",       32'(q),       32'h00);
        check("arst_q_valid", 32'(q_valid), 32'h0);
        check("arst_count",   32'(count),   32'h0);
        sb_reset();
        @(posedge clk);
        #1;
        sb_compare("arst_hold");
        @(negedge clk);
        rst = 1'b1;

        // Stall with two entries loaded
        drive(1'b1, 1'b0, 8'h11, 1'b1);
        drive(1'b1, 1'b0, 8'h22, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            check("stall_count",   32'(count),   32'h2);
            check("stall_q_valid", 32'(q_valid), 32'h0);
        end
        drive(1'b1, 1'b0, 8'h33, 1'b1);
        check("resume1_q_valid", 32'(q_valid), 32'h0);
        drive(1'b1, 1'b0, 8'h44, 1'b1);
        check("resume2_q",       32'(q),       32'h11);
        check("resume2_q_valid", 32'(q_valid), 32'h1);

        // Flush a full pipe while a new word is presented
        drive(1'b1, 1'b0, 8'hA1, 1'b1);
        drive(1'b1, 1'b0, 8'hA2, 1'b1);
        drive(1'b1, 1'b0, 8'hA3, 1'b1);
        drive(1'b1, 1'b0, 8'hA4, 1'b1);
        check("full_count", 32'(count), 32'h4);
        drive(1'b1, 1'b1, 8'h77, 1'b1);
        check("flush_q",       32'(q),       32'(RST_VAL));
        check("flush_q_valid", 32'(q_valid), 32'h0);
        check("flush_count",   32'(count),   32'h0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            check("post_flush_q_valid", 32'(q_valid), 32'h0);
        end

        // Bubbles: valid pattern 1,0,1,0 must reappear DEPTH edges later
        max_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, (i < 4) ? 8'(i + 1) : 8'h00, (i < 4) ? ((i % 2) == 0) : 1'b0);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (i >= 3 && i <= 6) begin
                check($sformatf("bubble%0d_q", i),       32'(q),       32'(i - 2));
                check($sformatf("bubble%0d_q_valid", i), 32'(q_valid), 32'(((i - 3) % 2) == 0));
            end
        end
        check("bubble_max_count", 32'(max_cnt), 32'h2);

        // Random traffic with occasional stalls and flushes
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

`ifdef DFF_PIPE_PARITY_EN
        // Corrupted parity on one word, clean words around it
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        check("par_flush", 32'(par_err), 32'h0);
        par_inject = 1'b1;
        drive(1'b1, 1'b0, 8'h03, 1'b1);
        par_inject = 1'b0;
        drive(1'b1, 1'b0, 8'h05, 1'b1);
        drive(1'b1, 1'b0, 8'h06, 1'b1);
        drive(1'b1, 1'b0, 8'h07, 1'b1);
        check("par_word_at_q", 32'(q),       32'h03);
        check("par_err_early", 32'(par_err), 32'h0);
        drive(1'b1, 1'b0, 8'h08, 1'b1);
        check("par_err_hit",   32'(par_err), 32'h1);
        drive(1'b1, 1'b0, 8'h09, 1'b1);
        check("par_err_clear", 32'(par_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit × DEPTH-stage register chain with a valid bit per stage.
- Adds clock enable (stall), synchronous flush, and an occupancy counter.
- Used as a generic delay line / pipeline-balancing element between datapath blocks.

Parameters:
- WIDTH, 8: data bits per stage; must be ≥1.
- DEPTH, 4: number of register stages, equal to the latency in enabled cycles; must be ≥1.
- RST_VAL, 0: value loaded into every data stage on reset or flush; WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  advance enable; 0 holds all stages.
- flush  input  1  synchronous clear of all stages.
- d  input  WIDTH  input data.
- d_valid  input  1  input data qualifier.
- q  output  WIDTH  data of stage DEPTH-1.
- q_valid  output  1  valid bit of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages currently held.

Behaviour:
- Reset (rst=0, asynchronous):
  - All data stages take RST_VAL; all valid bits, q_valid and count take 0; q = RST_VAL.
  - Deassertion takes effect at the first following clk edge.
- Priority each edge: rst > flush > en > hold.
- flush=1:
  - All data stages take RST_VAL and all valid bits clear, regardless of en.
  - count becomes 0.
  - Any d/d_valid presented in the same cycle is dropped.
- en=1, flush=0:
  - stage[0] ← d and valid[0] ← d_valid.
  - stage[i] ← stage[i-1] and valid[i] ← valid[i-1] for i = 1..DEPTH-1.
  - Data shifts even when its valid bit is 0.
- en=0, flush=0: all stages, valid bits and count hold.
- Latency: d presented on an edge with en=1 appears on q after exactly DEPTH en=1 edges. Stalled cycles do not count.
- q and q_valid are driven directly from the last-stage registers; there is no combinational path from d to q.
- count is a registered counter, not a popcount. On an en=1, flush=0 edge:
  - +1 if d_valid=1 and valid[DEPTH-1]=0;
  - -1 if d_valid=0 and valid[DEPTH-1]=1;
  - otherwise unchanged.
- count never exceeds DEPTH or underflows below 0. Both bounds are invariants and must be asserted in simulation.
- DEPTH=1: a single register stage; count is 1 bit.
- Reset asserted mid-stream discards all contents immediately, without waiting for clk.

Optional Feature:
- Macro: DFF_PIPE_PARITY_EN.
- Enabled:
  - Each stage stores an extra even-parity bit, computed from d at stage 0 and carried along the chain.
  - An extra output, par_err (1 bit, registered), is high in the cycle after q_valid=1 whenever q's recomputed parity mismatches the stored bit.
  - par_err resets to 0 and clears on flush.
  - A debug-only input, par_inject (1 bit), inverts the stage-0 parity bit when written.
- Disabled: par_err and par_inject ports do not exist; no parity storage is built.

Decomposition:
- Shared package dff_pkg:
  - function clog2_depth(DEPTH), giving the count width;
  - localparam defaults DFF_DEF_WIDTH = 8 and DFF_DEF_DEPTH = 4;
  - function even_parity(WIDTH-bit).
- One natural sub-module, dff_stage: a single WIDTH-bit + valid (+ parity) register with en, flush and RST_VAL.
- dff_pipe instantiates DEPTH dff_stage copies in a generate loop and adds the count logic.

Test Plan:
- Reset: rst=0 with en=1, d=8'hA5, d_valid=1 for 3 cycles → q=8'h00, q_valid=0, count=0 throughout, including asynchronously mid-cycle.
- Latency, WIDTH=8, DEPTH=4, en=1: d=8'h11,22,33,44 with d_valid=1 on consecutive edges → q=8'h11 with q_valid=1 on the 4th edge after 8'h11 is applied, then 22, 33, 44; count sequence 1,2,3,4,4.
- Stall: after loading 8'h11 and 8'h22, hold en=0 for 5 cycles → q, q_valid and count (2) unchanged; resume en=1 → 8'h11 reaches q exactly 2 enabled edges later.
- Flush with en=1, d=8'h77, d_valid=1 on a full pipe → next edge all valid=0, count=0, q=RST_VAL; 8'h77 never appears on q.
- Bubbles: d_valid pattern 1,0,1,0 with data 8'h01..04 → q_valid pattern 1,0,1,0 starting DEPTH edges later; count never exceeds 2.
- Parity (DFF_PIPE_PARITY_EN defined): par_inject=1 with d=8'h03 → par_err=1 for one cycle, one cycle after that word reaches q with q_valid=1; clean data keeps par_err=0.
